muxn_skid: RTL and testbench
============================

Name: muxn_skid

Overview:
- Parametrised N-way, WIDTH-bit select mux followed by a registered 2-entry skid buffer with valid/ready handshakes on both sides.
- Successor to the core's combinational mux2/mux3 for the pipelined datapath, where operand and result selection is registered per stage and must tolerate downstream stall and flush.
- Adds a sticky out-of-range select flag.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N, 3, number of input channels; must be at least 2.
- SELW, $clog2(N), select width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 = reset.
- d  input  N*WIDTH  packed inputs; channel i is d[i*WIDTH +: WIDTH].
- s  input  SELW  channel select.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block can accept a beat this cycle.
- y  output  WIDTH  head-of-buffer data.
- out_valid  output  1  y holds a valid beat.
- out_ready  input  1  downstream accepts y this cycle.
- flush  input  1  synchronous discard of all buffered beats.
- sel_err  output  1  sticky flag: an accepted beat had s >= N.
- err_clr  input  1  synchronous clear of sel_err.

Behaviour:
- Selection: s < N selects channel s. s >= N selects channel 0 (mux3 default) and counts as an error. Selection is combinational; it is sampled only on an accepted beat.
- Accept: in_valid && in_ready at a rising edge. Pop: out_valid && out_ready at a rising edge.
- Storage: main register (drives y) plus skid register. States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- Transitions (no flush):
  - EMPTY + accept -> ONE.
  - ONE + accept + pop -> ONE (new beat into main).
  - ONE + accept, no pop -> FULL (new beat into skid).
  - ONE + pop, no accept -> EMPTY.
  - FULL + pop -> ONE (skid moves to main).
  - FULL cannot accept.
  - All other combinations hold state.
- Latency: a beat accepted at edge k appears on y with out_valid=1 after edge k. Order is strictly FIFO.
- Timing: in_ready and out_valid are decoded from registered state only. There is no combinational path from out_ready to in_ready or from d/s to y.
- y holds its last value when out_valid=0. Consumers must not rely on its contents then.
- Flush: at the next edge, state -> EMPTY and any same-cycle accept is discarded. A same-cycle pop still completes downstream, but nothing is retained. Flush overrides all other transitions. sel_err is unaffected by flush.
- sel_err: set at the edge of an accepted beat with s >= N, excluding beats discarded by same-cycle flush. Cleared by err_clr. A simultaneous set and clear leaves it set. When N is a power of 2, sel_err stays 0.
- Reset (reset=0, asynchronous): state EMPTY, out_valid=0, in_ready=0, y=0, sel_err=0.
- Release: in_ready rises to 1 after the first rising edge following reset deassertion. A reset asserted mid-transfer drops all beats.

Test Plan:
- Reset, then with N=3, WIDTH=32 and out_ready=1, stream s=0,1,2 with d={0x33,0x22,0x11} (ch2..ch0) -> y=0x11,0x22,0x33 on consecutive cycles, each one cycle after its accept; in_ready stays 1.
- Stall: out_ready=0 and accept 0xA then 0xB -> FULL, in_ready=0, y=0xA. Then out_ready=1 for 2 cycles -> y=0xA then 0xB, then EMPTY. No beat is lost or duplicated.
- Out-of-range select: s=3 with d0=0x5A -> y=0x5A and sel_err=1. Pulse err_clr together with another s=3 accept -> sel_err stays 1. Pulse err_clr alone -> sel_err=0.
- Flush in FULL with a concurrent in_valid -> next cycle out_valid=0, in_ready=1. A subsequent beat 0x77 emerges alone.
- Assert reset asynchronously mid-clock while in ONE -> out_valid, y and sel_err go to 0 immediately. in_ready=0 until the first edge after release, then 1.
- N=4 build with all s values -> sel_err never asserts; each channel routes correctly.

Source files
------------

// File: rtl/muxn_skid.sv
// muxn_skid: N-way select mux feeding a registered 2-entry skid buffer with a sticky bad-select flag.
module muxn_skid #(
    parameter int WIDTH = 32,
    parameter int N     = 3,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] d,
    input  logic [SELW-1:0]    s,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   y,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               flush,
    output logic               sel_err,
    input  logic               err_clr
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d, skid_q, skid_d, sel_data;
    logic               err_q, err_d, live_q, acc, pop, oor;
    logic [31:0]        s_ext;

    // Unmatched selects fall through to channel 0.
    always_comb begin
        sel_data = d[WIDTH-1:0];
        for (int i = 1; i < N; i++)
            if (s == SELW'(i)) sel_data = d[i*WIDTH +: WIDTH];
    end

    assign s_ext     = 32'(s);
    assign oor       = s_ext >= 32'(N);
    assign out_valid = state_q != EMPTY;
    // live_q holds in_ready low until the first edge after reset release.
    assign in_ready  = live_q && state_q != FULL;
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign y         = main_q;
    assign sel_err   = err_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (acc) begin
                state_d = ONE;
                main_d  = sel_data;
            end
            ONE: if (acc && pop) main_d = sel_data;
                 else if (acc) begin
                     state_d = FULL;
                     skid_d  = sel_data;
                 end else if (pop) state_d = EMPTY;
            FULL: if (pop) begin
                state_d = ONE;
                main_d  = skid_q;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
        err_d = (err_q && !err_clr) || (acc && !flush && oor);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_muxn_skid.sv
// tb_muxn_skid: directed checks of muxn_skid with N=3 and N=4 instances.
module tb_muxn_skid;
    logic         clk = 0, reset = 0;
    logic [95:0]  d3 = '0;
    logic [1:0]   s3 = '0;
    logic         iv3 = 0, or3 = 0, fl3 = 0, ec3 = 0;
    logic         ir3, ov3, se3;
    logic [31:0]  y3;
    logic [127:0] d4 = '0;
    logic [1:0]   s4 = '0;
    logic         iv4 = 0, or4 = 0;
    logic         ir4, ov4, se4;
    logic [31:0]  y4;
    int           checks = 0, failures = 0;
    logic [31:0]  exp4 [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    always #5 clk = ~clk;

    muxn_skid #(.WIDTH(32), .N(3)) u3 (
        .clk(clk), .reset(reset), .d(d3), .s(s3), .in_valid(iv3), .in_ready(ir3),
        .y(y3), .out_valid(ov3), .out_ready(or3), .flush(fl3), .sel_err(se3), .err_clr(ec3)
    );

    muxn_skid #(.WIDTH(32), .N(4)) u4 (
        .clk(clk), .reset(reset), .d(d4), .s(s4), .in_valid(iv4), .in_ready(ir4),
        .y(y4), .out_valid(ov4), .out_ready(or4), .flush(1'b0), .sel_err(se4), .err_clr(1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_ov", 32'(ov3), 0);
        chk("rst_ir", 32'(ir3), 0);
        chk("rst_y", y3, 0);
        chk("rst_err", 32'(se3), 0);
        #12 reset = 1;
        chk("rel_ir_before_edge", 32'(ir3), 0);
        step;
        chk("rel_ir_after_edge", 32'(ir3), 1);
        chk("rel_ov", 32'(ov3), 0);
        // streaming with downstream always ready
        d3 = {32'h33, 32'h22, 32'h11};
        or3 = 1; iv3 = 1; s3 = 0;
        step;
        chk("str_y0", y3, 32'h11);
        chk("str_ov0", 32'(ov3), 1);
        chk("str_ir0", 32'(ir3), 1);
        s3 = 1;
        step;
        chk("str_y1", y3, 32'h22);
        chk("str_ir1", 32'(ir3), 1);
        s3 = 2;
        step;
        chk("str_y2", y3, 32'h33);
        chk("str_err", 32'(se3), 0);
        iv3 = 0;
        step;
        chk("str_drain", 32'(ov3), 0);
        // stall into FULL, then drain
        or3 = 0; iv3 = 1; s3 = 0; d3 = {32'h33, 32'h22, 32'hA};
        step;
        chk("stl_one_y", y3, 32'hA);
        d3[31:0] = 32'hB;
        step;
        chk("stl_full_ir", 32'(ir3), 0);
        chk("stl_full_y", y3, 32'hA);
        chk("stl_full_ov", 32'(ov3), 1);
        iv3 = 0; or3 = 1;
        step;
        chk("stl_pop_y", y3, 32'hB);
        chk("stl_pop_ir", 32'(ir3), 1);
        step;
        chk("stl_empty", 32'(ov3), 0);
        // out-of-range select
        iv3 = 1; s3 = 3; d3[31:0] = 32'h5A;
        step;
        chk("oor_y", y3, 32'h5A);
        chk("oor_err", 32'(se3), 1);
        ec3 = 1;
        step;
        chk("oor_set_wins", 32'(se3), 1);
        iv3 = 0;
        step;
        chk("oor_clr", 32'(se3), 0);
        ec3 = 0;
        step;
        // flush while FULL with concurrent in_valid
        or3 = 0; iv3 = 1; s3 = 0; d3[31:0] = 32'h1;
        step;
        d3[31:0] = 32'h2;
        step;
        chk("fl_full_ir", 32'(ir3), 0);
        fl3 = 1;
        step;
        chk("fl_ov", 32'(ov3), 0);
        chk("fl_ir", 32'(ir3), 1);
        // flush discards a same-cycle out-of-range accept
        s3 = 3;
        step;
        chk("fl_disc_ov", 32'(ov3), 0);
        chk("fl_disc_err", 32'(se3), 0);
        fl3 = 0; s3 = 0; d3[31:0] = 32'h77; or3 = 1;
        step;
        chk("fl_next_y", y3, 32'h77);
        chk("fl_next_ov", 32'(ov3), 1);
        iv3 = 0;
        step;
        chk("fl_next_alone", 32'(ov3), 0);
        // asynchronous reset while in ONE
        or3 = 0; iv3 = 1; s3 = 3; d3[31:0] = 32'h99;
        step;
        chk("ar_pre_y", y3, 32'h99);
        chk("ar_pre_err", 32'(se3), 1);
        iv3 = 0;
        #2 reset = 0;
        #1;
        chk("ar_ov", 32'(ov3), 0);
        chk("ar_y", y3, 0);
        chk("ar_err", 32'(se3), 0);
        chk("ar_ir", 32'(ir3), 0);
        #3 reset = 1;
        #1;
        chk("ar_ir_released", 32'(ir3), 0);
        step;
        chk("ar_ir_live", 32'(ir3), 1);
        // N=4: every select value is legal
        d4 = {32'h44, 32'h33, 32'h22, 32'h11};
        iv4 = 1; or4 = 1;
        for (int i = 0; i < 4; i++) begin
            s4 = 2'(i);
            step;
            chk($sformatf("n4_y%0d", i), y4, exp4[i]);
            chk($sformatf("n4_err%0d", i), 32'(se4), 0);
        end
        iv4 = 0;
        step;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
